// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver frame sequencer.
//   rx_state_e      : frame sequencer states
//   *_IDX           : bit indices reported by the edge/bit counter
//   PRESCALE_RST    : oversampling ratio held while in reset
//   stop_idx()      : bit index of the stop bit for a given parity setting
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Bit index 0 is the start bit, 1..8 the data bits, then parity (if any)
    // and finally the stop bit.
    localparam logic [3:0] START_IDX      = 4'd0;
    localparam logic [3:0] LAST_DATA_IDX  = 4'd8;
    localparam logic [3:0] PARITY_IDX     = 4'd9;
    localparam logic [3:0] STOP_IDX_PAR   = 4'd10;
    localparam logic [3:0] STOP_IDX_NOPAR = 4'd9;

    localparam logic [5:0] PRESCALE_RST   = 6'd8;

    function automatic logic [3:0] stop_idx(input logic par_en);
        return par_en ? STOP_IDX_PAR : STOP_IDX_NOPAR;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_if
// Bundle between the frame sequencer and the blocks around it (receiver top,
// edge/bit counter, sampler, deserializer, start/parity/stop checkers).
//   master : the sequencer; consumes line/config/counter/checker signals and
//            drives enables, latched config and frame-end pulses
//   slave  : the surrounding receiver blocks
// Signals:
//   i_RX_IN        serial line, idle high
//   i_PAR_EN       parity bit present (config)
//   i_Prescale     oversampling ratio 8/16/32 (config)
//   i_bit_cnt      current bit index from the counter
//   i_edge_cnt     current edge index from the counter
//   i_strt_glitch  start bit not low at its sample point
//   i_par_err      parity check result (valid on parity last edge)
//   i_stp_err      stop check result (valid on stop last edge)
//   o_prescale     latched prescale for counter and sampler
//   o_par_en       latched parity enable for the counter
//   o_cnt_enable   counter enable
//   o_cnt_clr      counter synchronous clear (wins over enable)
//   o_dat_samp_en  sampler enable
//   o_deser_en     deserializer shift enable
//   o_strt_chk_en / o_par_chk_en / o_stp_chk_en   checker enables
//   o_busy         frame in progress
//   o_data_valid   one-cycle pulse: frame received clean
//   o_par_error    one-cycle pulse: parity error
//   o_stp_error    one-cycle pulse: stop error
// -----------------------------------------------------------------------------
interface uart_rx_fsm_if;

    logic       i_RX_IN;
    logic       i_PAR_EN;
    logic [5:0] i_Prescale;
    logic [3:0] i_bit_cnt;
    logic [4:0] i_edge_cnt;
    logic       i_strt_glitch;
    logic       i_par_err;
    logic       i_stp_err;

    logic [5:0] o_prescale;
    logic       o_par_en;
    logic       o_cnt_enable;
    logic       o_cnt_clr;
    logic       o_dat_samp_en;
    logic       o_deser_en;
    logic       o_strt_chk_en;
    logic       o_par_chk_en;
    logic       o_stp_chk_en;
    logic       o_busy;
    logic       o_data_valid;
    logic       o_par_error;
    logic       o_stp_error;

    modport master (
        input  i_RX_IN, i_PAR_EN, i_Prescale, i_bit_cnt, i_edge_cnt,
               i_strt_glitch, i_par_err, i_stp_err,
        output o_prescale, o_par_en, o_cnt_enable, o_cnt_clr, o_dat_samp_en,
               o_deser_en, o_strt_chk_en, o_par_chk_en, o_stp_chk_en,
               o_busy, o_data_valid, o_par_error, o_stp_error
    );

    modport slave (
        output i_RX_IN, i_PAR_EN, i_Prescale, i_bit_cnt, i_edge_cnt,
               i_strt_glitch, i_par_err, i_stp_err,
        input  o_prescale, o_par_en, o_cnt_enable, o_cnt_clr, o_dat_samp_en,
               o_deser_en, o_strt_chk_en, o_par_chk_en, o_stp_chk_en,
               o_busy, o_data_valid, o_par_error, o_stp_error
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// Frame sequencer for the UART receiver. Waits for the line to drop in IDLE,
// freezes the frame configuration, then walks START -> DATA -> [PARITY] ->
// STOP following the edge/bit counter, and reports one data-valid or error
// pulse in the first IDLE cycle after the stop bit.
// Ports:
//   i_clk    oversampling clock
//   i_reset  synchronous, active-high reset
//   bus      uart_rx_fsm_if.master (line, config, counter, checkers, enables,
//            latched config, frame-end pulses)
// -----------------------------------------------------------------------------
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    uart_rx_fsm_if.master bus
);

    rx_state_e  state;
    rx_state_e  state_nxt;

    logic [5:0] prescale_q;
    logic       par_en_q;
    logic       par_flag;      // sticky parity error for the current frame
    logic       cnt_clr_q;
    logic       data_valid_q;
    logic       par_error_q;
    logic       stp_error_q;

    logic       last_edge;
    logic       start_done;
    logic       glitch_abort;
    logic       data_done;
    logic       parity_done;
    logic       stop_done;

    // Edge counter is 5 bits but prescale reaches 32, so compare at 6 bits.
    assign last_edge    = ({1'b0, bus.i_edge_cnt} == (prescale_q - 6'd1));

    assign start_done   = (state == START)  && last_edge && (bus.i_bit_cnt == START_IDX);
    assign glitch_abort = start_done && bus.i_strt_glitch;
    assign data_done    = (state == DATA)   && last_edge && (bus.i_bit_cnt == LAST_DATA_IDX);
    assign parity_done  = (state == PARITY) && last_edge && (bus.i_bit_cnt == PARITY_IDX);
    assign stop_done    = (state == STOP)   && last_edge && (bus.i_bit_cnt == stop_idx(par_en_q));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaulting every always_comb output before the case keeps
        // paths that do not assign it from inferring a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.i_RX_IN) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (start_done) begin
                    state_nxt = bus.i_strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (data_done) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (parity_done) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // The counter wraps to 0/0 by itself after the stop bit.
                if (stop_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, frozen configuration, sticky flag and frame-end pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (i_reset) begin
            state        <= IDLE;
            prescale_q   <= PRESCALE_RST;
            par_en_q     <= 1'b0;
            par_flag     <= 1'b0;
            cnt_clr_q    <= 1'b1;   // hold the counter cleared through reset
            data_valid_q <= 1'b0;
            par_error_q  <= 1'b0;
            stp_error_q  <= 1'b0;
        end else begin
            state <= state_nxt;

            // Config tracks its inputs only while idle; it is frozen for the
            // whole frame starting at the edge that moves us to START.
            if (state == IDLE) begin
                prescale_q <= bus.i_Prescale;
                par_en_q   <= bus.i_PAR_EN;
            end

            // A start glitch leaves the counter mid-bit; clear it in the
            // following IDLE cycle so the next START begins at 0/0.
            cnt_clr_q <= glitch_abort;

            if (parity_done) begin
                par_flag <= bus.i_par_err;
            end else if (stop_done) begin
                par_flag <= 1'b0;
            end

            data_valid_q <= stop_done && !par_flag && !bus.i_stp_err;
            par_error_q  <= stop_done && par_flag;
            stp_error_q  <= stop_done && bus.i_stp_err;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    assign bus.o_prescale    = prescale_q;
    assign bus.o_par_en      = par_en_q;
    assign bus.o_cnt_clr     = cnt_clr_q;
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_cnt_enable  = (state != IDLE);
    assign bus.o_dat_samp_en = (state != IDLE);
    assign bus.o_strt_chk_en = (state == START);
    assign bus.o_deser_en    = (state == DATA);
    assign bus.o_par_chk_en  = (state == PARITY);
    assign bus.o_stp_chk_en  = (state == STOP);
    assign bus.o_data_valid  = data_valid_q;
    assign bus.o_par_error   = par_error_q;
    assign bus.o_stp_error   = stp_error_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Self-checking bench for the UART receiver frame sequencer. A behavioural
// edge/bit counter closes the loop around the DUT; checker results are driven
// only at the sample point where the DUT is supposed to consume them.
// Cycle numbering inside a frame: cycle 0 is the cycle in which the line is
// first driven low; START is expected from cycle 1.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

    typedef struct {
        int ps;          // prescale driven before the frame
        int par_en;
        int glitch;      // start glitch at bit 0 last edge
        int par_err;     // parity error at parity last edge
        int stp_err;     // stop error at stop last edge
        int ps_late;     // prescale driven from cycle 20 on
        int exp_busy;    // cycles with o_busy=1
        int exp_deser;   // cycles with o_deser_en=1
        int exp_pulse;   // cycle of the frame-end pulse, -1 if none
        int exp_dv;
        int exp_pe;
        int exp_se;
        int exp_clr_cyc; // cycle of the o_cnt_clr pulse, -1 if none
    } vec_t;

    localparam int NVEC = 10;

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    uart_rx_fsm_if bus ();

    uart_rx_fsm dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int m_bit    = 0;
    int m_edge   = 0;
    logic [7:0] data_byte = 8'hA5;

    vec_t vecs [NVEC];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance one clock. The counter model consumes this cycle's clear/enable
    // and latched config, exactly as the real counter would at the edge.
    task automatic tick();
        int nb;
        int ne;
        nb = m_bit;
        ne = m_edge;
        if (bus.o_cnt_clr === 1'b1) begin
            nb = 0;
            ne = 0;
        end else if (bus.o_cnt_enable === 1'b1) begin
            if (m_edge == int'(bus.o_prescale) - 1) begin
                ne = 0;
                nb = (m_bit == (bus.o_par_en ? 10 : 9)) ? 0 : m_bit + 1;
            end else begin
                ne = m_edge + 1;
            end
        end
        @(posedge i_clk);
        #1;
        m_bit          = nb;
        m_edge         = ne;
        bus.i_bit_cnt  = 4'(nb);
        bus.i_edge_cnt = 5'(ne);
    endtask

    task automatic quiet_inputs();
        bus.i_RX_IN       = 1'b1;
        bus.i_strt_glitch = 1'b0;
        bus.i_par_err     = 1'b0;
        bus.i_stp_err     = 1'b0;
    endtask

    // Line and checker stimulus for cycle rel of a table frame.
    task automatic drive_line(input vec_t v, input int rel);
        int   stop;
        logic last;
        int   k;
        stop = (v.par_en != 0) ? 10 : 9;
        last = (m_edge == v.ps - 1);
        bus.i_strt_glitch = (v.glitch != 0) && (m_bit == 0) && last;
        bus.i_par_err     = (v.par_err != 0) && (v.par_en != 0) && (m_bit == 9) && last;
        bus.i_stp_err     = (v.stp_err != 0) && (m_bit == stop) && last;
        if (rel == 0) begin
            bus.i_RX_IN = 1'b0;
        end else if (v.glitch != 0) begin
            bus.i_RX_IN = 1'b1;
        end else if (rel <= v.ps) begin
            bus.i_RX_IN = 1'b0;
        end else if (rel <= 9 * v.ps) begin
            k = (rel - 1) / v.ps - 1;
            bus.i_RX_IN = data_byte[k];
        end else begin
            bus.i_RX_IN = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int first_busy = -1;
        int busy_cnt   = 0;
        int samp_cnt   = 0;
        int cen_cnt    = 0;
        int deser_cnt  = 0;
        int strt_cnt   = 0;
        int pchk_cnt   = 0;
        int schk_cnt   = 0;
        int dv_cnt     = 0;
        int pe_cnt     = 0;
        int se_cnt     = 0;
        int pulse_cyc  = -1;
        int clr_cnt    = 0;
        int clr_cyc    = -1;
        int ps_bad     = 0;
        int limit;
        string p;
        p     = $sformatf("v%0d_", idx);
        limit = 11 * v.ps + 6;

        quiet_inputs();
        bus.i_Prescale = 6'(v.ps);
        bus.i_PAR_EN   = (v.par_en != 0);
        tick();
        tick();
        check({p, "idle_busy"}, int'(bus.o_busy), 0);

        for (int rel = 0; rel <= limit; rel++) begin
            drive_line(v, rel);
            if (rel == 20) bus.i_Prescale = 6'(v.ps_late);
            if (bus.o_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = rel;
                if (bus.o_prescale != 6'(v.ps)) ps_bad++;
            end
            samp_cnt  += int'(bus.o_dat_samp_en);
            cen_cnt   += int'(bus.o_cnt_enable);
            deser_cnt += int'(bus.o_deser_en);
            strt_cnt  += int'(bus.o_strt_chk_en);
            pchk_cnt  += int'(bus.o_par_chk_en);
            schk_cnt  += int'(bus.o_stp_chk_en);
            dv_cnt    += int'(bus.o_data_valid);
            pe_cnt    += int'(bus.o_par_error);
            se_cnt    += int'(bus.o_stp_error);
            if (bus.o_data_valid || bus.o_par_error || bus.o_stp_error) pulse_cyc = rel;
            if (bus.o_cnt_clr) begin
                clr_cnt++;
                clr_cyc = rel;
            end
            tick();
        end

        check({p, "first_busy"}, first_busy, 1);
        check({p, "busy_cycles"}, busy_cnt, v.exp_busy);
        check({p, "samp_cycles"}, samp_cnt, v.exp_busy);
        check({p, "cnt_en_cycles"}, cen_cnt, v.exp_busy);
        check({p, "deser_cycles"}, deser_cnt, v.exp_deser);
        check({p, "strt_chk_cycles"}, strt_cnt, v.ps);
        check({p, "par_chk_cycles"}, pchk_cnt,
              ((v.par_en != 0) && (v.glitch == 0)) ? v.ps : 0);
        check({p, "stp_chk_cycles"}, schk_cnt, (v.glitch == 0) ? v.ps : 0);
        check({p, "data_valid_cnt"}, dv_cnt, v.exp_dv);
        check({p, "par_error_cnt"}, pe_cnt, v.exp_pe);
        check({p, "stp_error_cnt"}, se_cnt, v.exp_se);
        check({p, "pulse_cycle"}, pulse_cyc, v.exp_pulse);
        check({p, "cnt_clr_cnt"}, clr_cnt, (v.exp_clr_cyc >= 0) ? 1 : 0);
        check({p, "cnt_clr_cycle"}, clr_cyc, v.exp_clr_cyc);
        check({p, "prescale_frozen_bad"}, ps_bad, 0);
        check({p, "prescale_after"}, int'(bus.o_prescale), v.ps_late);
    endtask

    function automatic int other_outs();
        return int'({bus.o_par_en, bus.o_cnt_enable, bus.o_dat_samp_en,
                     bus.o_deser_en, bus.o_strt_chk_en, bus.o_par_chk_en,
                     bus.o_stp_chk_en, bus.o_busy, bus.o_data_valid,
                     bus.o_par_error, bus.o_stp_error});
    endfunction

    initial begin
        int clr_hi;
        int dv_tot;
        int se_tot;
        int busy_tot;
        int pulse_tot;

        //            ps par gl pe se late busy deser pulse dv pe se clr
        vecs[0] = '{ 8, 0, 0, 0, 0,  8,  80,  64,  81, 1, 0, 0, -1};
        vecs[1] = '{16, 1, 0, 1, 0, 16, 176, 128, 177, 0, 1, 0, -1};
        vecs[2] = '{ 8, 0, 1, 0, 0,  8,   8,   0,  -1, 0, 0, 0,  9};
        vecs[3] = '{ 8, 0, 0, 0, 1,  8,  80,  64,  81, 0, 0, 1, -1};
        vecs[4] = '{32, 1, 0, 0, 0, 32, 352, 256, 353, 1, 0, 0, -1};
        vecs[5] = '{16, 0, 0, 0, 0, 16, 160, 128, 161, 1, 0, 0, -1};
        vecs[6] = '{32, 0, 1, 0, 0, 32,  32,   0,  -1, 0, 0, 0, 33};
        vecs[7] = '{ 8, 1, 0, 1, 1,  8,  88,  64,  89, 0, 1, 1, -1};
        vecs[8] = '{ 8, 0, 0, 0, 0, 32,  80,  64,  81, 1, 0, 0, -1};
        vecs[9] = '{16, 1, 1, 0, 0, 16,  16,   0,  -1, 0, 0, 0, 17};

        // ---------------- reset state --------------------------------------
        quiet_inputs();
        bus.i_Prescale = 6'd32;
        bus.i_PAR_EN   = 1'b1;
        bus.i_bit_cnt  = 4'd0;
        bus.i_edge_cnt = 5'd0;
        i_reset        = 1'b1;
        clr_hi         = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            clr_hi += int'(bus.o_cnt_clr);
        end
        check("rst_cnt_clr_cycles", clr_hi, 3);
        check("rst_prescale", int'(bus.o_prescale), 8);
        check("rst_other_outputs", other_outs(), 0);
        i_reset = 1'b0;
        tick();
        check("post_rst_cnt_clr", int'(bus.o_cnt_clr), 0);
        check("post_rst_busy", int'(bus.o_busy), 0);

        // ---------------- table-driven frames ------------------------------
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // ---------------- stop error, then back-to-back frame --------------
        quiet_inputs();
        bus.i_Prescale = 6'd8;
        bus.i_PAR_EN   = 1'b0;
        tick();
        tick();
        dv_tot = 0;
        se_tot = 0;
        for (int rel = 0; rel <= 175; rel++) begin
            bus.i_RX_IN   = !((rel == 0) || (rel == 81));
            bus.i_stp_err = (rel < 81) && (m_bit == 9) && (m_edge == 7);
            if (rel == 81) begin
                check("b2b_stp_error", int'(bus.o_stp_error), 1);
                check("b2b_dv_low", int'(bus.o_data_valid), 0);
            end
            if (rel == 82) begin
                check("b2b_restart_busy", int'(bus.o_busy), 1);
                check("b2b_restart_start", int'(bus.o_strt_chk_en), 1);
            end
            if (rel == 162) check("b2b_second_dv", int'(bus.o_data_valid), 1);
            dv_tot += int'(bus.o_data_valid);
            se_tot += int'(bus.o_stp_error);
            tick();
        end
        check("b2b_dv_total", dv_tot, 1);
        check("b2b_se_total", se_tot, 1);

        // ---------------- reset in the middle of DATA ----------------------
        quiet_inputs();
        tick();
        tick();
        busy_tot  = 0;
        pulse_tot = 0;
        for (int rel = 0; rel <= 120; rel++) begin
            bus.i_RX_IN = (rel != 0);
            i_reset     = (rel == 20);
            if (rel == 20) check("rst_mid_in_data", int'(bus.o_deser_en), 1);
            if (rel == 21) begin
                check("rst_mid_busy", int'(bus.o_busy), 0);
                check("rst_mid_cnt_clr", int'(bus.o_cnt_clr), 1);
                check("rst_mid_enables", int'({bus.o_cnt_enable, bus.o_deser_en,
                                               bus.o_dat_samp_en}), 0);
            end
            if (rel == 22) check("rst_mid_clr_release", int'(bus.o_cnt_clr), 0);
            if (rel >= 21) begin
                busy_tot  += int'(bus.o_busy);
                pulse_tot += int'(bus.o_data_valid) + int'(bus.o_par_error)
                           + int'(bus.o_stp_error);
            end
            tick();
        end
        i_reset = 1'b0;
        check("rst_mid_busy_after", busy_tot, 0);
        check("rst_mid_no_pulses", pulse_tot, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
